// File: rtl/red_pitaya_idly_cal.sv
// IDELAY auto-calibration: sweeps each ADC channel's taps against a training
// pattern, centres the delay in the widest passing window, else passes manual controls.
module red_pitaya_idly_cal #(
  parameter logic [13:0] PATTERN    = 14'h2AAA,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SAMPLES    = 256
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cal_start_i,
  input  logic [55:0] adc_dat_i,
  input  logic [27:0] man_rst_i,
  input  logic [27:0] man_ce_i,
  input  logic [27:0] man_inc_i,
  input  logic [19:0] idly_cnt_i,
  output logic [27:0] idly_rst_o,
  output logic [27:0] idly_ce_o,
  output logic [27:0] idly_inc_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic [3:0]  cal_err_o,
  output logic [19:0] cal_tap_o,
  output logic [23:0] cal_win_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_SETTLE, S_CHECK, S_EVAL,
    S_STEP, S_CENTER, S_APPLY, S_VERIFY, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  ch;
  logic [4:0]  tap, run_start, best_start, target, target_c, run_start_nxt;
  logic [5:0]  run_len, best_len, run_len_nxt;
  logic [15:0] cnt;
  logic        fail;
  logic [27:0] ch_mask, rst_p, step_p;
  logic [13:0] sample;
  logic [4:0]  tap_rb;
  logic        settle_last, sample_last, apply_last, verify_last;

  assign ch_mask     = 28'h7F << (7 * ch);
  assign sample      = adc_dat_i[14*ch +: 14];
  assign tap_rb      = idly_cnt_i[5*ch +: 5];
  assign settle_last = (cnt == 16'(SETTLE_CYC - 1));
  assign sample_last = (cnt == 16'(SAMPLES - 1));
  assign verify_last = (cnt == 16'(SETTLE_CYC));
  assign apply_last  = (cnt == ({10'd0, target, 1'b0} - 16'd1));
  assign target_c    = (best_len == '0) ? '0 : best_start + best_len[5:1];

  // Run bookkeeping: the run being closed or extended by this tap's verdict.
  assign run_len_nxt   = fail ? '0 : run_len + 6'd1;
  assign run_start_nxt = (!fail && run_len == '0) ? tap : run_start;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rst_p     = '0;
    step_p    = '0;
    case (state)
      S_IDLE:   if (cal_start_i) state_nxt = S_RST;
      S_RST: begin
        rst_p     = ch_mask;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: if (settle_last) state_nxt = S_CHECK;
      S_CHECK:  if (sample_last) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = (tap == 5'd31) ? S_CENTER : S_STEP;
      S_STEP: begin
        step_p    = ch_mask;
        state_nxt = S_SETTLE;
      end
      S_CENTER: begin
        rst_p     = ch_mask;
        state_nxt = (target_c == '0) ? S_VERIFY : S_APPLY;
      end
      S_APPLY: begin
        if (!cnt[0]) step_p = ch_mask;
        if (apply_last) state_nxt = S_VERIFY;
      end
      S_VERIFY: if (verify_last) state_nxt = (ch == 2'd3) ? S_DONE : S_RST;
      S_DONE:   state_nxt = cal_start_i ? S_RST : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idly_rst_o <= '0;
      idly_ce_o  <= '0;
      idly_inc_o <= '0;
      cal_busy_o <= 1'b0;
      cal_done_o <= 1'b0;
      cal_err_o  <= '0;
      cal_tap_o  <= '0;
      cal_win_o  <= '0;
      ch         <= '0;
      tap        <= '0;
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
      target     <= '0;
      cnt        <= '0;
      fail       <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        idly_rst_o <= man_rst_i;
        idly_ce_o  <= man_ce_i;
        idly_inc_o <= man_inc_i;
      end else begin
        idly_rst_o <= rst_p;
        idly_ce_o  <= step_p;
        idly_inc_o <= step_p;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (cal_start_i) begin
            cal_busy_o <= 1'b1;
            cal_done_o <= 1'b0;
            cal_err_o  <= '0;
            cal_tap_o  <= '0;
            cal_win_o  <= '0;
            ch         <= '0;
          end
        end
        S_RST: begin
          tap        <= '0;
          run_len    <= '0;
          run_start  <= '0;
          best_len   <= '0;
          best_start <= '0;
          cnt        <= '0;
        end
        S_SETTLE: begin
          if (settle_last) begin
            cnt  <= '0;
            fail <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (sample != PATTERN) fail <= 1'b1;
          cnt <= sample_last ? '0 : cnt + 16'd1;
        end
        S_EVAL: begin
          run_len   <= run_len_nxt;
          run_start <= run_start_nxt;
          // Strict compare keeps the earliest of equally long windows.
          if (run_len_nxt > best_len) begin
            best_len   <= run_len_nxt;
            best_start <= run_start_nxt;
          end
        end
        S_STEP:   tap <= tap + 5'd1;
        S_CENTER: begin
          target <= target_c;
          cnt    <= '0;
          if (best_len == '0) cal_err_o[ch] <= 1'b1;
        end
        S_APPLY:  cnt <= apply_last ? '0 : cnt + 16'd1;
        S_VERIFY: begin
          if (verify_last) begin
            if (tap_rb != target) cal_err_o[ch] <= 1'b1;
            cal_tap_o[5*ch +: 5] <= target;
            cal_win_o[6*ch +: 6] <= best_len;
            cnt <= '0;
            if (ch == 2'd3) begin
              cal_busy_o <= 1'b0;
              cal_done_o <= 1'b1;
            end else begin
              ch <= ch + 2'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_idly_cal.sv
// Bench for red_pitaya_idly_cal: per-line IDELAY tap model feeding a training
// pattern that is clean only at table-selected taps; results checked against a window search.
module tb_red_pitaya_idly_cal;

  localparam logic [13:0] PAT = 14'h2AAA;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        cal_start_i;
  logic [55:0] adc_dat_i;
  logic [27:0] man_rst_i, man_ce_i, man_inc_i;
  logic [19:0] idly_cnt_i;
  logic [27:0] idly_rst_o, idly_ce_o, idly_inc_o;
  logic        cal_busy_o, cal_done_o;
  logic [3:0]  cal_err_o;
  logic [19:0] cal_tap_o;
  logic [23:0] cal_win_o;

  red_pitaya_idly_cal #(.PATTERN(PAT), .SETTLE_CYC(3), .SAMPLES(4)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .cal_start_i(cal_start_i), .adc_dat_i(adc_dat_i),
    .man_rst_i(man_rst_i), .man_ce_i(man_ce_i), .man_inc_i(man_inc_i),
    .idly_cnt_i(idly_cnt_i), .idly_rst_o(idly_rst_o), .idly_ce_o(idly_ce_o),
    .idly_inc_o(idly_inc_o), .cal_busy_o(cal_busy_o), .cal_done_o(cal_done_o),
    .cal_err_o(cal_err_o), .cal_tap_o(cal_tap_o), .cal_win_o(cal_win_o)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  bit          pass_tbl [4][32];
  bit          stuck = 1'b0;
  int unsigned dly [28];
  int unsigned exp_tap [4];
  int unsigned exp_win [4];
  logic [3:0]  exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // IDELAY line model: reset to 0, ce+inc increments, ce alone decrements, wraps at 32.
  always @(posedge clk) begin
    for (int i = 0; i < 28; i++) begin
      if (idly_rst_o[i])     dly[i] <= 0;
      else if (idly_ce_o[i]) dly[i] <= idly_inc_o[i] ? (dly[i] + 1) % 32 : (dly[i] + 31) % 32;
    end
  end

  // Channel data is clean only if all 7 lines agree and sit on a passing tap.
  bit ok;
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      ok = pass_tbl[c][dly[7*c]];
      for (int l = 1; l < 7; l++) if (dly[7*c+l] != dly[7*c]) ok = 1'b0;
      adc_dat_i[14*c +: 14] = ok ? PAT : PAT ^ (14'd1 << $urandom_range(13, 0));
      idly_cnt_i[5*c +: 5]  = stuck ? 5'd0 : 5'(dly[7*c]);
    end
  end

  task automatic tbl_set(input int c, input int lo, input int hi);
    for (int t = 0; t < 32; t++) pass_tbl[c][t] = (t >= lo && t <= hi);
  endtask

  task automatic tbl_rand(input int c);
    int kind;
    int lo;
    kind = $urandom_range(0, 3);
    case (kind)
      0: tbl_set(c, 1, 0);
      1: tbl_set(c, 0, 31);
      2: for (int t = 0; t < 32; t++) pass_tbl[c][t] = ($urandom_range(0, 3) != 0);
      default: begin
        lo = $urandom_range(0, 31);
        tbl_set(c, lo, $urandom_range(lo, 31));
        lo = $urandom_range(0, 31);
        for (int t = lo; t < 32 && t < lo + int'($urandom_range(1, 8)); t++) pass_tbl[c][t] = 1'b1;
      end
    endcase
  endtask

  // Reference: scan for maximal passing runs, keep first strictly-longest, park at centre.
  task automatic compute_exp();
    int t, s, best, bstart;
    for (int c = 0; c < 4; c++) begin
      best = 0; bstart = 0; t = 0;
      while (t < 32) begin
        if (pass_tbl[c][t]) begin
          s = t;
          while (t < 32 && pass_tbl[c][t]) t++;
          if (t - s > best) begin best = t - s; bstart = s; end
        end else begin
          t++;
        end
      end
      exp_win[c] = best;
      exp_tap[c] = (best == 0) ? 0 : bstart + best / 2;
      exp_err[c] = (best == 0) || (stuck && exp_tap[c] != 0);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    cal_start_i = 1'b1;
    @(negedge clk);
    cal_start_i = 1'b0;
    check("start_busy", cal_busy_o, 1);
    check("start_done", cal_done_o, 0);
    check("start_err", cal_err_o, 0);
  endtask

  task automatic wait_done(input bit poke, input bit chain);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (cal_done_o) begin got = 1'b1; break; end
      man_rst_i   = 28'($urandom());
      man_ce_i    = 28'($urandom());
      man_inc_i   = 28'($urandom());
      cal_start_i = poke && (c % 97 == 40);
    end
    man_rst_i = '0; man_ce_i = '0; man_inc_i = '0; cal_start_i = 1'b0;
    check("done_seen", got, 1);
    check("busy_end", cal_busy_o, 0);
    check("err", cal_err_o, exp_err);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("tap%0d", c), cal_tap_o[5*c +: 5], exp_tap[c]);
      check($sformatf("win%0d", c), cal_win_o[6*c +: 6], exp_win[c]);
      for (int l = 0; l < 7; l++)
        check($sformatf("line%0d_%0d", c, l), dly[7*c+l], exp_tap[c]);
    end
    if (chain) begin
      cal_start_i = 1'b1;
      @(negedge clk);
      cal_start_i = 1'b0;
      check("chain_busy", cal_busy_o, 1);
      check("chain_done", cal_done_o, 0);
    end else begin
      repeat (2) @(negedge clk);
      check("done_hold", cal_done_o, 1);
    end
  endtask

  logic [27:0] rnd;
  int unsigned saved;

  initial begin
    rstn_i = 1'b0; cal_start_i = 1'b0;
    man_rst_i = '0; man_ce_i = '0; man_inc_i = '0;
    for (int c = 0; c < 4; c++) tbl_set(c, 0, 31);
    repeat (3) @(negedge clk);
    check("rst_busy", cal_busy_o, 0);
    check("rst_done", cal_done_o, 0);
    check("rst_err", cal_err_o, 0);
    check("rst_tap", cal_tap_o, 0);
    check("rst_win", cal_win_o, 0);
    check("rst_ce", idly_ce_o, 0);
    rstn_i = 1'b1;

    // ch0 window 10..20, others always pass
    tbl_set(0, 10, 20);
    compute_exp();
    start_pulse();
    wait_done(0, 0);

    // two windows, tie, never-passing channel; start pokes while busy
    tbl_set(0, 0, 31);
    tbl_set(1, 3, 6);
    for (int t = 20; t <= 29; t++) pass_tbl[1][t] = 1'b1;
    tbl_set(2, 2, 5);
    for (int t = 10; t <= 13; t++) pass_tbl[2][t] = 1'b1;
    tbl_set(3, 1, 0);
    compute_exp();
    start_pulse();
    wait_done(1, 0);

    // readback stuck at 0
    stuck = 1'b1;
    tbl_set(0, 10, 20);
    for (int c = 1; c < 4; c++) tbl_rand(c);
    compute_exp();
    start_pulse();
    wait_done(0, 0);
    stuck = 1'b0;

    // randomized tables, last one restarted straight from DONE
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) tbl_rand(c);
      compute_exp();
      start_pulse();
      wait_done(r == 1, r == 2);
      if (r == 2) wait_done(0, 0);
    end

    // async reset in the middle of ch0 CHECK
    start_pulse();
    repeat (5) @(negedge clk);
    check("mid_busy", cal_busy_o, 1);
    saved = dly[0];
    rstn_i = 1'b0;
    #1;
    check("ar_busy", cal_busy_o, 0);
    check("ar_done", cal_done_o, 0);
    check("ar_err", cal_err_o, 0);
    check("ar_tap", cal_tap_o, 0);
    check("ar_win", cal_win_o, 0);
    check("ar_rst", idly_rst_o, 0);
    check("ar_ce", idly_ce_o, 0);
    check("ar_inc", idly_inc_o, 0);
    repeat (2) @(negedge clk);
    check("ar_tap_kept", dly[0], saved);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", cal_busy_o, 0);

    // manual passthrough, one cycle latency
    man_ce_i = 28'h1;
    #1;
    check("man_lat", idly_ce_o, 0);
    @(negedge clk);
    check("man_ce", idly_ce_o, 28'h1);
    rnd = 28'($urandom());
    man_inc_i = rnd;
    man_ce_i  = '0;
    @(negedge clk);
    check("man_inc", idly_inc_o, rnd);
    check("man_ce0", idly_ce_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/red_pitaya_idly_cal.md
# red_pitaya_idly_cal

Automatic IDELAY calibration controller for the 4-channel ADC LVDS input. On request it sweeps each channel's 7 data-line IDELAY taps from 0 to 31 while the ADC emits a fixed training pattern. It locates the widest passing window and parks the delay at the window centre. When idle, it passes the bus-driven manual IDELAY controls straight through. It sits between the housekeeping register block and the ADC input delay primitives.

## Interface
Parameters:
- `PATTERN`, 14'h2AAA, expected 14-bit sample on every channel during calibration.
- `SETTLE_CYC`, 16, wait cycles after any tap change before sampling (1..255).
- `SAMPLES`, 256, consecutive samples compared per tap (1..65535).

Ports:
- `clk_i`, in, 1, ADC/system clock.
- `rstn_i`, in, 1, reset; asynchronous, active-low.
- `cal_start_i`, in, 1, one-cycle start pulse.
- `adc_dat_i`, in, 4*14, deserialized samples; ch n = bits [14n+13:14n]; valid every cycle.
- `man_rst_i`, `man_ce_i`, `man_inc_i`, in, 4*7 each, manual IDELAY controls from the register block.
- `idly_cnt_i`, in, 4*5, current tap value per channel.
- `idly_rst_o`, `idly_ce_o`, `idly_inc_o`, out, 4*7 each, registered IDELAY controls.
- `cal_busy_o`, out, 1, calibration in progress.
- `cal_done_o`, out, 1, set at end of a run; cleared by the next start.
- `cal_err_o`, out, 4, per-channel failure: no passing tap, or tap readback mismatch.
- `cal_tap_o`, out, 4*5, chosen tap per channel.
- `cal_win_o`, out, 4*6, best window length per channel (0..32).

## Operation
- Reset: all outputs 0; FSM in IDLE.
- IDLE:
  - Outputs `idly_*_o` are driven from `man_*_i`, registered one cycle.
  - `cal_start_i` causes: busy=1, done=0, err=0, tap/win outputs cleared, ch=0, go to RST.
- While busy:
  - `man_*_i` are ignored.
  - `cal_start_i` is ignored.
- States, per channel ch (all 7 lines of ch driven together; other channels' controls are 0):
  - RST: `idly_rst_o` for ch's 7 bits = 1 for one cycle. Set tap=0, run=0, best_len=0. Go to SETTLE.
  - SETTLE: wait SETTLE_CYC cycles, then go to CHECK.
  - CHECK: compare ch's sample to PATTERN for SAMPLES consecutive cycles. A sticky fail flag is set on any mismatch. Go to EVAL.
  - EVAL:
    - Pass: run_len++, and run_start=tap if run_len was 0.
    - Fail: close the run (run_len=0).
    - Best window update: if the current run's length > best_len (strict), replace best_start/best_len. Ties keep the earlier window.
    - If tap<31, go to STEP; else go to CENTER.
  - STEP: ce=inc=1 on ch's 7 bits for one cycle, tap++. Go to SETTLE.
  - CENTER:
    - target = best_start + (best_len>>1), 5-bit.
    - If best_len=0: target=0 and err[ch]=1.
    - Pulse rst one cycle, then go to APPLY.
  - APPLY: issue `target` ce+inc pulses, each one cycle high followed by one cycle low. Target 0 issues no pulses. Go to VERIFY.
  - VERIFY:
    - Wait SETTLE_CYC cycles, then compare `idly_cnt_i[ch]` to target; mismatch sets err[ch].
    - Write `cal_tap_o[ch]`=target and `cal_win_o[ch]`=best_len.
    - If ch<3: ch++, go to RST. Else go to DONE.
  - DONE: busy=0, done=1 for as long as the sticky done persists. Return to IDLE.
- Windows do not wrap: a run still open at tap 31 is evaluated as a closed run at tap 31.
- An error on one channel does not stop calibration of the remaining channels.

## Timing
- Manual passthrough latency: 1 cycle.
- Start → busy=1: next cycle.
- Per tap: 1 (RST/STEP) + SETTLE_CYC + SAMPLES + 1 (EVAL) cycles.
- Apply phase: 1 + 2·target + SETTLE_CYC + 1 cycles.
- A channel's result outputs update in the VERIFY exit cycle. done rises the cycle after the last channel's VERIFY exit.
- Asynchronous reset mid-run: all outputs go to 0 immediately. IDELAY taps are left as they were. The FSM restarts in IDLE.
- `cal_start_i` asserted in the same cycle as DONE→IDLE is taken as a new start.

## Test plan
- Ch0 passes taps 10..20 and ch1–3 pass every tap → tap0=15, win0=11; taps1–3=16, win=32; err=0; done=1.
- Ch1 passes 3..6 and 20..29 → tap1=25, win1=10.
- Ch2 tie, windows 2..5 and 10..13 → tap2=4, win2=4 (earlier window kept).
- Ch3 never passes → err=4'b1000, tap3=0, win3=0. Other channels still calibrate; done=1.
- Model `idly_cnt_i` stuck at 0 with target 15 → corresponding err bit set.
- Reset asserted mid-CHECK → all outputs 0 immediately; IDLE after release. `cal_start_i` while busy has no effect. In IDLE, `man_ce_i`=28'h1 appears on `idly_ce_o` one cycle later.
